// File: rtl/rate_limiter_pkg.sv
// Shared types and constants for the token-bucket rate limiter.
// The state encoding is visible on the status port so software and the bench can observe it.
package rate_limiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Packet length in bytes sits in the low half-word of tuser on the first beat.
  localparam int TUSER_LEN_LO = 0;
  localparam int TUSER_LEN_HI = 15;

endpackage

// File: rtl/rate_limiter_if.sv
// AXI4-Stream bundle used on both sides of the rate limiter.
interface rate_limiter_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/rate_limiter_token_bucket.sv
// Saturating byte bucket: refills every cycle, debits on packet admission, reports tokens >= len.
// Kept standalone so a per-port limiter can instantiate one bucket per port.
module rate_limiter_token_bucket #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sw_rst,
  input  logic         rl_en,
  input  logic [W-1:0] refill_val,
  input  logic [W-1:0] bucket_max,
  input  logic [W-1:0] debit,
  input  logic [15:0]  len,
  output logic [W-1:0] tokens,
  output logic         ok
);

  // One extra bit holds tokens + refill without wrapping; debit never exceeds tokens.
  logic [W:0] sum;

  assign sum = {1'b0, tokens} - {1'b0, debit} + {1'b0, refill_val};
  assign ok  = tokens >= W'(len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tokens <= '0;
    end else if (sw_rst) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
      tokens <= '0;
    end else if (!rl_en) begin
      tokens <= bucket_max;
    end else if (sum > {1'b0, bucket_max}) begin
      tokens <= bucket_max;
    end else begin
      tokens <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/rate_limiter.sv
// Token-bucket packet admission for the TX path: a packet starts only when the bucket covers its
// length, then streams through with zero latency. Holds the admission FSM and the handshake gating.
module rate_limiter
  import rate_limiter_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  rate_limiter_if.slave                 s_axis,
  rate_limiter_if.master                m_axis,
  input  logic                          sw_rst,
  input  logic                          rl_en,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] refill_val,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] bucket_max,
  output logic [C_S_AXI_DATA_WIDTH-1:0] tokens,
  output state_e                        state
);

  localparam int M_STRB_W = C_M_AXIS_DATA_WIDTH / 8;

  state_e                          state_d;
  logic                            pass;
  logic                            fwd;
  logic                            admit;
  logic                            ok;
  logic                            bucket_ok;
  logic [15:0]                     len;
  logic [C_S_AXI_DATA_WIDTH-1:0]   debit;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  data_in;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] user_in;

  assign data_in = s_axis.tdata;
  assign user_in = s_axis.tuser;
  assign len     = user_in[TUSER_LEN_HI:TUSER_LEN_LO];
  assign ok      = ~rl_en | bucket_ok;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state <= ST_IDLE;
    else              state <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a value held and no latch is inferred.
    state_d = state;
    pass    = 1'b0;
    admit   = 1'b0;
    case (state)
      ST_IDLE, ST_WAIT: begin
        // A soft reset only retires a waiting packet; it never cuts one already streaming.
        if (sw_rst) begin
          state_d = ST_IDLE;
        end else if (s_axis.tvalid) begin
          if (ok) begin
            pass = 1'b1;
            if (m_axis.tready) begin
              admit   = 1'b1;
              state_d = s_axis.tlast ? ST_IDLE : ST_SEND;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_SEND: begin
        pass = 1'b1;
        if (s_axis.tvalid && m_axis.tready && s_axis.tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Both handshake directions stay low while the global reset is asserted.
  assign fwd   = pass & axi_aresetn;
  assign debit = (admit & rl_en) ? C_S_AXI_DATA_WIDTH'(len) : '0;

  assign m_axis.tdata  = C_M_AXIS_DATA_WIDTH'(data_in);
  assign m_axis.tstrb  = M_STRB_W'(s_axis.tstrb);
  assign m_axis.tuser  = C_M_AXIS_TUSER_WIDTH'(user_in);
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tvalid = s_axis.tvalid & fwd;
  assign s_axis.tready = m_axis.tready & fwd;

  rate_limiter_token_bucket #(
    .W (C_S_AXI_DATA_WIDTH)
  ) u_bucket (
    .clk        (axi_aclk),
    .rst_n      (axi_aresetn),
    .sw_rst     (sw_rst),
    .rl_en      (rl_en),
    .refill_val (refill_val),
    .bucket_max (bucket_max),
    .debit      (debit),
    .len        (len),
    .tokens     (tokens),
    .ok         (bucket_ok)
  );

endmodule

// File: tb/tb_rate_limiter.sv
// Scoreboard bench for rate_limiter: a driver queues every beat it offers, and a negedge monitor
// compares DUT outputs against a cycle-level token-bucket reference model.
module tb_rate_limiter;
  import rate_limiter_pkg::*;

  localparam int TIMEOUT = 4000;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        sw_rst;
  logic        rl_en;
  logic [31:0] refill_val;
  logic [31:0] bucket_max;
  logic [31:0] rl_tokens;
  state_e      rl_state;

  rate_limiter_if #(.DATA_W(256), .USER_W(128)) s_if ();
  rate_limiter_if #(.DATA_W(256), .USER_W(128)) m_if ();

  rate_limiter dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .s_axis      (s_if.slave),
    .m_axis      (m_if.master),
    .sw_rst      (sw_rst),
    .rl_en       (rl_en),
    .refill_val  (refill_val),
    .bucket_max  (bucket_max),
    .tokens      (rl_tokens),
    .state       (rl_state)
  );

  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  bit    rand_rdy = 0;
  bit    rand_sw  = 0;
  beat_t exp_q[$];

  // Reference model state: bucket contents and packet progress, in plain arithmetic.
  longint mdl_tok   = 0;
  state_e mdl_state = ST_IDLE;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within %0d cycles, one was required", name, TIMEOUT);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: checks handshake outputs, bucket and state every cycle, and pops the scoreboard.
  always @(negedge clk) begin
    logic [15:0] len;
    bit          ok, pass, hs;
    longint      debit, nxt;
    beat_t       got, want;
    if (!rst_n) begin
      check("reset_m_tvalid", 256'(m_if.tvalid), 256'(0));
      check("reset_s_tready", 256'(s_if.tready), 256'(0));
      check("reset_tokens", 256'(rl_tokens), 256'(0));
      check("reset_state", 256'(rl_state), 256'(ST_IDLE));
      mdl_tok   = 0;
      mdl_state = ST_IDLE;
    end else begin
      len  = s_if.tuser[15:0];
      ok   = !rl_en || (mdl_tok >= longint'(len));
      pass = (mdl_state == ST_SEND) ? 1'b1 : (!sw_rst && s_if.tvalid && ok);
      hs   = s_if.tvalid && m_if.tready && pass;
      check("m_tvalid", 256'(m_if.tvalid), 256'(s_if.tvalid && pass));
      check("s_tready", 256'(s_if.tready), 256'(m_if.tready && pass));
      check("tokens", 256'(rl_tokens), 256'(mdl_tok));
      check("state", 256'(rl_state), 256'(mdl_state));
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 256'(1), 256'(0));
        end else begin
          want     = exp_q.pop_front();
          got.data = m_if.tdata;
          got.strb = m_if.tstrb;
          got.user = m_if.tuser;
          got.last = m_if.tlast;
          check("beat_data", got.data, want.data);
          check("beat_strb", 256'(got.strb), 256'(want.strb));
          check("beat_user", 256'(got.user), 256'(want.user));
          check("beat_last", 256'(got.last), 256'(want.last));
        end
      end
      debit = (hs && mdl_state != ST_SEND && rl_en) ? longint'(len) : 0;
      nxt   = mdl_tok - debit + longint'(refill_val);
      if (nxt > longint'(bucket_max)) nxt = longint'(bucket_max);
      if (sw_rst)      mdl_tok = 0;
      else if (!rl_en) mdl_tok = longint'(bucket_max);
      else             mdl_tok = nxt;
      if (mdl_state == ST_SEND) begin
        if (hs && s_if.tlast) mdl_state = ST_IDLE;
      end else if (sw_rst) begin
        mdl_state = ST_IDLE;
      end else if (s_if.tvalid) begin
        if (!ok)     mdl_state = ST_WAIT;
        else if (hs) mdl_state = s_if.tlast ? ST_IDLE : ST_SEND;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) m_if.tready = ($urandom_range(0, 3) != 0);
      if (rand_sw)  sw_rst = ($urandom_range(0, 40) == 0);
    end
  end

  // Offers one packet beat by beat; reports handshake cycles and the bucket right after the debit.
  task automatic send_pkt(input int len, input int nbeats, input int gap_max,
                          output int first_cyc, output int last_cyc, output logic [31:0] tok_after);
    beat_t bt;
    int    n;
    bit    done;
    first_cyc = -1;
    last_cyc  = -1;
    tok_after = '0;
    for (int b = 0; b < nbeats; b++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          s_if.tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bt.data = rnd256();
      bt.strb = $urandom;
      bt.user = {$urandom, $urandom, $urandom, $urandom};
      if (b == 0) bt.user[15:0] = len[15:0];
      bt.last     = (b == nbeats - 1);
      s_if.tdata  = bt.data;
      s_if.tstrb  = bt.strb;
      s_if.tuser  = bt.user;
      s_if.tlast  = bt.last;
      s_if.tvalid = 1'b1;
      exp_q.push_back(bt);
      n    = 0;
      done = 0;
      while (!done) begin
        @(negedge clk);
        done = s_if.tready;
        if (done) begin
          if (b == 0) first_cyc = cyc;
          last_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (done && b == 0) tok_after = rl_tokens;
        if (!done) begin
          n++;
          if (n >= TIMEOUT) begin
            timeout_fail("beat_handshake");
            void'(exp_q.pop_back());
            s_if.tvalid = 1'b0;
            return;
          end
        end
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int          f0, l0, f1, l1, c0, dummy_f, dummy_l;
    logic [31:0] tok_a, tok_dummy, tok5;
    bit   [4:0]  pat;
    rst_n       = 1'b0;
    sw_rst      = 1'b0;
    rl_en       = 1'b0;
    refill_val  = 32'd0;
    bucket_max  = 32'd2048;
    s_if.tdata  = '0;
    s_if.tstrb  = '0;
    s_if.tuser  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Transparent mode: three back-to-back 64B packets with no bubbles.
    send_pkt(64, 2, 0, f0, l0, tok_dummy);
    send_pkt(64, 2, 0, dummy_f, dummy_l, tok_dummy);
    send_pkt(64, 2, 0, f1, l1, tok_dummy);
    check("passthru_bubbles", 256'(l1 - f0), 256'(5));

    // Bucket starts empty after a soft reset; refill 8/cycle admits 64B on cycle 8.
    rl_en      = 1'b1;
    refill_val = 32'd8;
    sw_rst     = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    c0     = cyc;
    send_pkt(64, 2, 0, f0, l0, tok_a);
    check("admit_latency", 256'(f0 - c0), 256'(8));
    check("tokens_after_debit", 256'(tok_a), 256'(8));

    // Saturation at bucket_max, then a full-bucket packet admitted without delay.
    refill_val = 32'd1000;
    bucket_max = 32'd1500;
    tick(10);
    check("tokens_saturated", 256'(rl_tokens), 256'(1500));
    c0 = cyc;
    send_pkt(1500, 47, 0, f0, l0, tok_a);
    check("full_bucket_immediate", 256'(f0 - c0), 256'(0));
    check("full_bucket_tokens", 256'(tok_a), 256'(1000));

    // Three beats under toggling backpressure; SEND holds until the tlast handshake.
    pat = 5'b10101;
    fork
      send_pkt(96, 3, 0, f0, l0, tok_dummy);
      begin
        for (int i = 0; i < 5; i++) begin
          m_if.tready = pat[i];
          if (i == 1) begin
            @(negedge clk);
            check("send_held_under_bp", 256'(rl_state), 256'(ST_SEND));
          end
          @(posedge clk);
          #1;
        end
        m_if.tready = 1'b1;
      end
    join
    check("bp_beat_span", 256'(l0 - f0), 256'(4));
    check("idle_after_tlast", 256'(rl_state), 256'(ST_IDLE));

    // Soft reset on the 2nd beat of a streaming packet: the packet completes, the bucket empties.
    refill_val = 32'd1;
    bucket_max = 32'd2048;
    tick(1);
    fork
      send_pkt(160, 5, 0, f0, l0, tok_dummy);
      begin
        @(posedge clk);
        #1;
        sw_rst = 1'b1;
        @(posedge clk);
        #1;
        sw_rst = 1'b0;
        tok5   = rl_tokens;
      end
    join
    check("sw_rst_no_truncate", 256'(l0 - f0), 256'(4));
    check("sw_rst_tokens", 256'(tok5), 256'(0));
    fork
      send_pkt(64, 2, 0, f0, l0, tok_dummy);
      begin
        tick(3);
        check("next_pkt_waits", 256'(rl_state), 256'(ST_WAIT));
      end
    join

    // Randomized traffic, backpressure, soft resets and reprogrammed bucket limits.
    rand_rdy = 1;
    rand_sw  = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      rl_en      = ($urandom_range(0, 3) != 0);
      refill_val = $urandom_range(4, 64);
      bucket_max = $urandom_range(320, 2047);
      len        = $urandom_range(0, 300);
      send_pkt(len, (len == 0) ? 1 : (len + 31) / 32, 2, dummy_f, dummy_l, tok_dummy);
    end
    rand_rdy    = 0;
    rand_sw     = 0;
    tick(1);
    m_if.tready = 1'b1;
    sw_rst      = 1'b0;
    tick(2);
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

    // Global reset asserted while a packet waits for tokens.
    rl_en      = 1'b1;
    refill_val = 32'd2;
    bucket_max = 32'd2048;
    sw_rst     = 1'b1;
    tick(1);
    sw_rst      = 1'b0;
    s_if.tuser  = 128'd512;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    tick(5);
    check("wait_state", 256'(rl_state), 256'(ST_WAIT));
    check("wait_tokens", 256'(rl_tokens), 256'(10));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_s_tready", 256'(s_if.tready), 256'(0));
    check("arst_m_tvalid", 256'(m_if.tvalid), 256'(0));
    check("arst_tokens", 256'(rl_tokens), 256'(0));
    check("arst_state", 256'(rl_state), 256'(ST_IDLE));
    s_if.tvalid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
